hazard_scoreboard: RTL and testbench

//  Decode-stage data-hazard detector. Consumes the per-instruction Rs/Rt/Rd identifiers and valid bits

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_match.sv | 35 +++
 rtl/hazard_scoreboard.sv | 83 ++++++++
 tb/tb_hazard_scoreboard.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Build option: HAZARD_FORWARD_EN (EX/MEM/WB forwarding present, only load-use stalls).
package hazard_pkg;

   localparam int REG_W     = 3;
   localparam int DEF_DEPTH = 3;

   localparam int STG_EX  = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB  = 2;

   // One in-flight destination: {v, rd, ld}
   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] rd;
      logic             ld;
   } entry_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational comparator: does a read source hit any tracked in-flight destination.
// Build option: HAZARD_FORWARD_EN restricts the hit to a load sitting in the EX entry.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  entry_t [DEPTH-1:0] i_entries,
   input  logic [REG_W-1:0]   i_src,
   input  logic               i_src_valid,
   output logic               o_hit
);

   logic w_match;
   logic w_unused;

   always_comb begin
      w_match = 1'b0;
`ifdef HAZARD_FORWARD_EN
      // Forwarding covers every ALU producer; only a load in EX has no data yet
      w_match = i_entries[STG_EX].v & i_entries[STG_EX].ld &
                (i_entries[STG_EX].rd == i_src);
`else
      for (int i = 0; i < DEPTH; i++) begin
         if (i_entries[i].v && (i_entries[i].rd == i_src)) begin
            w_match = 1'b1;
         end
      end
`endif
   end

   assign w_unused = ^i_entries;
   assign o_hit    = i_src_valid & w_match;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard detector: tracks in-flight destinations and freezes decode on a hit.
// Build option: HAZARD_FORWARD_EN (load-use only stalls; otherwise full EX/MEM/WB scoreboard).
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] Rs,
   input  logic [REG_W-1:0] Rt,
   input  logic [REG_W-1:0] Rd,
   input  logic             Rs_valid,
   input  logic             Rt_valid,
   input  logic             Rd_valid,
   input  logic             id_is_load,
   input  logic             flush,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);

   entry_t [DEPTH-1:0] r_entries;
   logic [CNT_W-1:0]   r_count;

   logic   w_hit_rs;
   logic   w_hit_rt;
   logic   w_raw_hz;
   logic   w_stall;
   entry_t w_entry_in;

   hazard_match #(.DEPTH(DEPTH)) u_match_rs (
      .i_entries   (r_entries),
      .i_src       (Rs),
      .i_src_valid (Rs_valid),
      .o_hit       (w_hit_rs)
   );

   hazard_match #(.DEPTH(DEPTH)) u_match_rt (
      .i_entries   (r_entries),
      .i_src       (Rt),
      .i_src_valid (Rt_valid),
      .o_hit       (w_hit_rt)
   );

   // A flushed decode instruction is squashed, so it never stalls
   assign w_raw_hz = id_valid & (w_hit_rs | w_hit_rt);
   assign w_stall  = w_raw_hz & ~flush;

   always_comb begin
      w_entry_in = '0;
      if (!flush && !w_stall) begin
         w_entry_in.v  = id_valid & Rd_valid;
         w_entry_in.rd = Rd;
         w_entry_in.ld = id_is_load;
      end
   end

   // Downstream stages advance every cycle so a producer always drains
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_entries <= '0;
      end else begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            r_entries[i] <= r_entries[i-1];
         end
         r_entries[STG_EX] <= w_entry_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (w_stall && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign stall       = w_stall;
   assign stall_count = r_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (default and HAZARD_FORWARD_EN builds).
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, Rs_valid, Rt_valid, Rd_valid, id_is_load, flush;
   logic [2:0] Rs, Rt, Rd;
   logic       stall, stall_s;
   logic [15:0] stall_count;
   logic [3:0]  stall_count_s;

   int checks   = 0;
   int failures = 0;
   int n_dut_st = 0;

   // expected {stall, count16, count4}
   logic [20:0] exp_q[$];

   logic       m_v[3];
   logic [2:0] m_rd[3];
   logic       m_ld[3];
   int         m_tot;
   int         m_c4;
   logic       m_last_stall;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .Rs(Rs), .Rt(Rt), .Rd(Rd),
      .Rs_valid(Rs_valid), .Rt_valid(Rt_valid), .Rd_valid(Rd_valid),
      .id_is_load(id_is_load), .flush(flush), .stall(stall), .stall_count(stall_count)
   );

   hazard_scoreboard #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .Rs(Rs), .Rt(Rt), .Rd(Rd),
      .Rs_valid(Rs_valid), .Rt_valid(Rt_valid), .Rd_valid(Rd_valid),
      .id_is_load(id_is_load), .flush(flush), .stall(stall_s), .stall_count(stall_count_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic mstall();
      logic hs, ht;
      hs = 1'b0;
      ht = 1'b0;
`ifdef HAZARD_FORWARD_EN
      if (m_v[0] && m_ld[0]) begin
         if (m_rd[0] == Rs) hs = 1'b1;
         if (m_rd[0] == Rt) ht = 1'b1;
      end
`else
      for (int i = 0; i < 3; i++) begin
         if (m_v[i]) begin
            if (m_rd[i] == Rs) hs = 1'b1;
            if (m_rd[i] == Rt) ht = 1'b1;
         end
      end
`endif
      return id_valid & ((Rs_valid & hs) | (Rt_valid & ht)) & ~flush;
   endfunction

   function automatic logic [15:0] lo16(input int v);
      logic [31:0] t;
      t = v;
      return t[15:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_v[i] = 1'b0; m_rd[i] = 3'd0; m_ld[i] = 1'b0;
      end
      m_tot = 0;
      m_c4  = 0;
   endtask

   task automatic set_in(input logic iv, input logic [2:0] rs, input logic rsv,
                         input logic [2:0] rt, input logic rtv, input logic [2:0] rd,
                         input logic rdv, input logic ld, input logic fl);
      id_valid = iv; Rs = rs; Rs_valid = rsv; Rt = rt; Rt_valid = rtv;
      Rd = rd; Rd_valid = rdv; id_is_load = ld; flush = fl;
   endtask

   // Called at posedge+1; returns at the next posedge+1
   task automatic drive(input logic iv, input logic [2:0] rs, input logic rsv,
                        input logic [2:0] rt, input logic rtv, input logic [2:0] rd,
                        input logic rdv, input logic ld, input logic fl);
      logic        st;
      logic [20:0] e;
      logic [3:0]  c4;
      set_in(iv, rs, rsv, rt, rtv, rd, rdv, ld, fl);
      st = mstall();
      m_last_stall = st;
      c4 = m_c4[3:0];
      exp_q.push_back({st, lo16(m_tot), c4});
      @(negedge clk);
      e = exp_q.pop_front();
      check("stall", {31'd0, stall}, {31'd0, e[20]});
      check("stall_sat", {31'd0, stall_s}, {31'd0, e[20]});
      check("count16", {16'd0, stall_count}, {16'd0, e[19:4]});
      check("count4", {28'd0, stall_count_s}, {28'd0, e[3:0]});
      if (stall) n_dut_st++;
      @(posedge clk);
      for (int i = 2; i > 0; i--) begin
         m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_ld[i] = m_ld[i-1];
      end
      m_v[0]  = (fl || st) ? 1'b0 : (iv & rdv);
      m_rd[0] = rd;
      m_ld[0] = ld;
      if (st) begin
         m_tot++;
         if (m_c4 != 15) m_c4++;
      end
      #1;
   endtask

   task automatic nop();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic alu(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
      drive(1'b1, rs, 1'b1, rt, 1'b1, rd, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [2:0] rd, input logic [2:0] rs);
      drive(1'b1, rs, 1'b1, 3'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
   endtask

   // Decode holds the consumer until the model says it proceeds
   task automatic alu_hold(input string tag, input logic [2:0] rd,
                           input logic [2:0] rs, input logic [2:0] rt);
      int n;
      n = 0;
      do begin
         alu(rd, rs, rt);
         n++;
      end while (m_last_stall && n < 8);
      check({tag, "_bound"}, {31'd0, m_last_stall}, 32'd0);
   endtask

   initial begin
      model_reset();
      m_last_stall = 1'b0;
      rst = 1'b1;
      set_in(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
      #3;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_count16", {16'd0, stall_count}, 32'd0);
      check("rst_count4", {28'd0, stall_count_s}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: ALU producer then dependent ALU consumer
      n_dut_st = 0;
      alu(3'd1, 3'd2, 3'd3);
      alu_hold("t1", 3'd4, 3'd1, 3'd5);
`ifdef HAZARD_FORWARD_EN
      check("t1_stalls", n_dut_st, 0);
      check("t1_count", {16'd0, stall_count}, 32'd0);
`else
      check("t1_stalls", n_dut_st, 3);
      check("t1_count", {16'd0, stall_count}, 32'd3);
`endif
      repeat (3) nop();

      // 2: load-use, then ALU producer of the same register
      n_dut_st = 0;
      load(3'd2, 3'd6);
      alu_hold("t2_ld", 3'd3, 3'd2, 3'd2);
`ifdef HAZARD_FORWARD_EN
      check("t2_ld_stalls", n_dut_st, 1);
`else
      check("t2_ld_stalls", n_dut_st, 3);
`endif
      repeat (3) nop();
      n_dut_st = 0;
      alu(3'd2, 3'd6, 3'd6);
      alu_hold("t2_alu", 3'd3, 3'd2, 3'd2);
`ifdef HAZARD_FORWARD_EN
      check("t2_alu_stalls", n_dut_st, 0);
`else
      check("t2_alu_stalls", n_dut_st, 3);
`endif
      repeat (3) nop();

      // 3: hazard with flush; squashed Rd=r7 must not be tracked
      n_dut_st = 0;
      load(3'd1, 3'd0);
      drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
      check("t3_stalls", n_dut_st, 0);
      repeat (3) nop();

      // 4: unread source field and non-valid decode slot
      n_dut_st = 0;
      alu(3'd1, 3'd2, 3'd3);
      drive(1'b1, 3'd1, 1'b0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 3'd1, 1'b1, 3'd1, 1'b1, 3'd6, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
      check("t4_stalls", n_dut_st, 0);
      repeat (3) nop();

      // 5: reset during the second stall cycle
      load(3'd1, 3'd2);
      alu(3'd4, 3'd1, 3'd5);
      set_in(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
      #2;
      check("t5_pre_stall", {31'd0, stall}, {31'd0, mstall()});
      rst = 1'b1;
      #1;
      check("t5_rst_stall", {31'd0, stall}, 32'd0);
      check("t5_rst_count16", {16'd0, stall_count}, 32'd0);
      check("t5_rst_count4", {28'd0, stall_count_s}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_dut_st = 0;
      alu(3'd4, 3'd1, 3'd5);
      check("t5_reissue_stalls", n_dut_st, 0);

      // 6: accumulate 20+ stall cycles; 4-bit counter saturates at 15
      for (int p = 0; p < 30 && m_tot < 20; p++) begin
         load(3'd1, 3'd0);
         alu_hold("t6", 3'd4, 3'd1, 3'd5);
      end
      check("t6_reached", {31'd0, m_tot >= 20}, 32'd1);
      repeat (3) nop();
      check("t6_sat", {28'd0, stall_count_s}, 32'd15);
      check("t6_count16", {16'd0, stall_count}, {16'd0, lo16(m_tot)});
      load(3'd3, 3'd0);
      alu_hold("t6_more", 3'd4, 3'd3, 3'd3);
      repeat (3) nop();
      check("t6_sat_hold", {28'd0, stall_count_s}, 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
